// File: rtl/inst_enc_pkg.sv
// Shared definitions for the instruction encoder: field layout of the 16-bit
// CPU word, the controller state encoding and the word-packing helper.
package inst_enc_pkg;

    localparam int WORD_W   = 16;
    localparam int IMM_W    = 8;
    localparam int OP_LSB   = 0;
    localparam int OP_W     = 5;
    localparam int RD_LSB   = 5;
    localparam int RD_W     = 3;
    localparam int RS_LSB   = 8;
    localparam int RS_W     = 3;
    localparam int SIMM_LSB = 11;
    localparam int SIMM_W   = 5;
    localparam int LIMM_LSB = 8;
    localparam int LIMM_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } state_e;

    // Long form reuses the rs slot for the upper immediate bits.
    function automatic logic [WORD_W-1:0] encode_word(
        input logic [OP_W-1:0]  op,
        input logic [RD_W-1:0]  rd,
        input logic [RS_W-1:0]  rs,
        input logic [IMM_W-1:0] imm,
        input logic             is_long
    );
        logic [WORD_W-1:0] w;
        w = '0;
        w[OP_LSB +: OP_W] = op;
        w[RD_LSB +: RD_W] = rd;
        if (is_long) begin
            w[LIMM_LSB +: LIMM_W] = imm;
        end else begin
            w[RS_LSB +: RS_W]     = rs;
            w[SIMM_LSB +: SIMM_W] = imm[SIMM_W-1:0];
        end
        return w;
    endfunction

    function automatic logic imm_too_wide(input logic [IMM_W-1:0] imm);
        return |imm[IMM_W-1:SIMM_W];
    endfunction

endpackage

// File: rtl/inst_enc_fifo.sv
// enc_fifo: small first-word-fall-through buffer for encoded words, with a
// synchronous flush that empties it in one cycle.
module enc_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] used_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (used_q == '0);
    assign full    = (used_q == CNT_W'(DEPTH));
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   used_q <= used_q + CNT_W'(1);
                2'b01:   used_q <= used_q - CNT_W'(1);
                default: used_q <= used_q;
            endcase
        end
    end

endmodule

// File: rtl/inst_enc.sv
// inst_enc: packs instruction fields into 16-bit words and writes them to
// consecutive memory addresses. Define INST_ENC_RANGE_CHECK_EN to reject
// short-form immediates above 31 (sticky err) instead of truncating them.
module inst_enc
    import inst_enc_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [2:0]        in_rd,
    input  logic [2:0]        in_rs,
    input  logic [7:0]        in_imm,
    input  logic              in_long,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              err,
    output logic              full
);

    localparam logic [ADDR_W:0] ADDR_SPAN = {1'b1, {ADDR_W{1'b0}}};

    state_e              state_q;
    logic [ADDR_W-1:0]   wr_addr_q, mem_addr_q;
    logic [WORD_W-1:0]   mem_wdata_q;
    logic                mem_we_q, err_q;
    logic [ADDR_W:0]     count_q, acc_cnt_q, acc_limit_q;

    logic                fifo_empty, fifo_full, fifo_push, fifo_pop;
    logic [WORD_W-1:0]   fifo_dout, enc_word, wr_data;
    logic                run, acc_done, xfer, accept, drain, bypass, do_write;

    assign run      = (state_q == ST_RUN);
    assign acc_done = (acc_cnt_q == acc_limit_q);
    assign in_ready = run && !fifo_full && !start && !acc_done;
    assign xfer     = in_valid && in_ready;
    assign enc_word = encode_word(in_op, in_rd, in_rs, in_imm, in_long);

`ifdef INST_ENC_RANGE_CHECK_EN
    logic imm_bad;
    assign imm_bad = !in_long && imm_too_wide(in_imm);
    assign accept  = xfer && !imm_bad;
`else
    assign accept  = xfer;
`endif

    // An empty buffer lets the fresh word go straight to the write stage, which
    // gives single-cycle latency; otherwise the oldest buffered word goes first.
    assign drain     = run && !start && !fifo_empty;
    assign bypass    = accept && fifo_empty;
    assign fifo_push = accept && !fifo_empty;
    assign fifo_pop  = drain;
    assign do_write  = drain || bypass;
    assign wr_data   = drain ? fifo_dout : enc_word;

    enc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (start),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (enc_word),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_addr_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            acc_cnt_q   <= '0;
            acc_limit_q <= '0;
        end else if (start) begin
            state_q     <= ST_RUN;
            wr_addr_q   <= base_addr;
            mem_we_q    <= 1'b0;
            count_q     <= '0;
            err_q       <= 1'b0;
            acc_cnt_q   <= '0;
            acc_limit_q <= ADDR_SPAN - {1'b0, base_addr};
        end else begin
            mem_we_q <= do_write;
            if (do_write) begin
                mem_addr_q  <= wr_addr_q;
                mem_wdata_q <= wr_data;
                wr_addr_q   <= wr_addr_q + ADDR_W'(1);
                count_q     <= count_q + (ADDR_W+1)'(1);
                if (&wr_addr_q) state_q <= ST_FULL;
            end
            if (accept) acc_cnt_q <= acc_cnt_q + (ADDR_W+1)'(1);
`ifdef INST_ENC_RANGE_CHECK_EN
            if (xfer && imm_bad) err_q <= 1'b1;
`endif
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign err       = err_q;
    assign full      = (state_q == ST_FULL);

endmodule

// File: doc/inst_enc.md
INST_ENC -- requirements
Module: inst_enc

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory address width.
REQ-002 Parameter FIFO_DEPTH, default 2, encoded-word buffer entries.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle pulse: load base_addr, flush buffer, enter RUN.
REQ-007 base_addr  in  ADDR_W  first write address, sampled on start.
REQ-008 in_valid  in  1  instruction fields valid.
REQ-009 in_ready  out  1  encoder accepts fields this cycle.
REQ-010 in_op  in  5  opcode, goes to word[4:0].
REQ-011 in_rd  in  3  destination register, goes to word[7:5].
REQ-012 in_rs  in  3  source register, goes to word[10:8] (short form only).
REQ-013 in_imm  in  8  unsigned immediate.
REQ-014 in_long  in  1  1 selects the long-immediate form.
REQ-015 mem_we  out  1  instruction-memory write strobe, registered.
REQ-016 mem_addr  out  ADDR_W  write address, registered.
REQ-017 mem_wdata  out  16  encoded instruction, registered.
REQ-018 count  out  ADDR_W+1  words written since last start.
REQ-019 err  out  1  sticky immediate-range error.
REQ-020 full  out  1  high in state FULL.

Function
REQ-021 Short form: word = {in_imm[4:0], in_rs, in_rd, in_op}.
REQ-022 Long form: word = {in_imm[7:0], in_rd, in_op}; in_rs is ignored.
REQ-023 Register-only ops use the short form with in_imm=0, so word[15:11]=0.
REQ-024 FSM states: IDLE (after reset), RUN, FULL; start moves any state to RUN; RUN moves to FULL when the write to address 2^ADDR_W-1 completes.
REQ-025 Handshake: transfer when in_valid && in_ready; the encoded word is pushed into the FIFO at that edge.
REQ-026 in_ready = RUN && !fifo_full && !start && !acc_done.
- acc_done sets once the number of accepted words reaches 2^ADDR_W - base_addr, so no accepted word is ever dropped.
REQ-027 Drain: when the FIFO is non-empty and the state is RUN, one write is issued per cycle.
- Writes use consecutive addresses starting at base_addr.
- mem_we pulses high for one cycle with mem_addr and mem_wdata.
- count increments for each write.
REQ-028 Latency: a word accepted at edge N, with the FIFO empty, is presented on mem_* in the cycle after edge N (mem_we high).
REQ-029 Simultaneous push and pop at a full FIFO: in_ready stays low, so no push occurs.
REQ-030 Address does not wrap past 2^ADDR_W-1; FULL holds until the next start.
REQ-031 start mid-operation: pending FIFO entries are dropped, count, err and acc_done are cleared, and mem_we is low on the cycle after start.

Reset
REQ-032 Reset values:
- State IDLE, FIFO empty.
- in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
- count=0, err=0, full=0.
REQ-033 Reset asserted mid-drain aborts immediately; no further mem_we pulses occur.

Configuration
REQ-034 Macro INST_ENC_RANGE_CHECK_EN governs immediate-range checking.
- Defined: a short-form transfer with in_imm>31 is consumed but not written, err sets, and count is unchanged.
- Undefined: in_imm is truncated to [4:0] silently, and err stays 0.

Structure
REQ-035 A shared package holds:
- the field position/width constants (OP, RD, RS, short IMM, long IMM);
- the FSM state encoding;
- the CPU word width of 16.
REQ-036 The FIFO is the one sub-module, enc_fifo (depth FIFO_DEPTH, width 16).

Verification
REQ-037 start base_addr=0x10; op=0x03 rd=2 rs=5 short imm=0 -> mem_we with addr 0x10, wdata 0x0543, count=1.
REQ-038 op=0x1A rd=1 long imm=0xA5 -> wdata 0xA53A.
REQ-039 op=0x0B rd=4 rs=3 short imm=17 -> wdata 0x8B8B; then short imm=40 -> with the macro: no write and err=1; without the macro: wdata has imm bits 0b01000.
REQ-040 base_addr=0xFE, three back-to-back valids:
- writes go to 0xFE and 0xFF;
- the third valid sees in_ready=0;
- full=1, count=2.
REQ-041 in_valid held with mem side continuous: one write per cycle, addresses consecutive, no gaps after the first.
REQ-042 start asserted with 2 entries pending -> no further mem_we, count=0, next accepted word written at the new base_addr.
